img_rsz_blk_comp_arb: RTL and testbench

Parametrised, registered scheduler between the block buffer and the "Compute" stage of the image resizer. Each cycle it selects one block whose accumulator is complete, in either fixed raster-priority or round-robin mode, and holds that block's index stable on a valid/ready channel until Compute accepts it. On the accept cycle it pulses a one-hot flush back to the block buffer. It also counts accepted blocks per frame and flags frame completion.

---
 rtl/img_rsz_blk_comp_arb_pkg.sv | 31 +++
 rtl/img_rsz_blk_comp_arb_rr_pick.sv | 36 +++
 rtl/img_rsz_blk_comp_arb.sv | 142 ++++++++++++++
 tb/tb_img_rsz_blk_comp_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_rsz_blk_comp_arb_pkg.sv
// Shared image-resizer package: frame/block geometry defaults, index-width helper,
// and the enums used by the Compute-stage block arbiter.
package img_rsz_blk_comp_arb_pkg;

  localparam int unsigned RSZ_IMG_WIDTH_SIZE  = 64;
  localparam int unsigned RSZ_IMG_HEIGHT_SIZE = 64;
  localparam int unsigned RSZ_BLK_SIZE        = 8;

  localparam int unsigned BLK_X_NUM_DEF = RSZ_IMG_WIDTH_SIZE / RSZ_BLK_SIZE;
  localparam int unsigned BLK_Y_NUM_DEF = RSZ_IMG_HEIGHT_SIZE / RSZ_BLK_SIZE;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned X_IDX_W_DEF = idx_w(BLK_X_NUM_DEF);
  localparam int unsigned Y_IDX_W_DEF = idx_w(BLK_Y_NUM_DEF);
  localparam int unsigned CNT_W_DEF   = $clog2(BLK_X_NUM_DEF * BLK_Y_NUM_DEF + 1);

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/img_rsz_blk_comp_arb_rr_pick.sv
// img_rsz_rr_pick: priority picker over a linear eligibility vector. Searches upward
// from i_start, wrapping past TOTAL-1 to 0, and returns the first set position.
//   i_elig  : eligibility, bit L = linear block index L
//   i_start : first position searched (must be < TOTAL)
//   o_found : any bit of i_elig set
//   o_l     : picked linear index (0 when nothing found)
module img_rsz_rr_pick #(
  parameter int unsigned TOTAL = 64,
  parameter int unsigned L_W   = 6
) (
  input  logic [TOTAL-1:0] i_elig,
  input  logic [L_W-1:0]   i_start,
  output logic             o_found,
  output logic [L_W-1:0]   o_l
);

  int unsigned      v_idx;
  logic [TOTAL-1:0] v_bits;

  always_comb begin
    o_found = 1'b0;
    o_l     = '0;
    v_idx   = 0;
    v_bits  = '0;
    for (int unsigned k = 0; k < TOTAL; k++) begin
      v_idx = 32'(i_start) + k;
      if (v_idx >= TOTAL) v_idx = v_idx - TOTAL;
      v_bits = i_elig >> v_idx;
      if (!o_found && v_bits[0]) begin
        o_found = 1'b1;
        o_l     = L_W'(v_idx);
      end
    end
  end

endmodule

// File: rtl/img_rsz_blk_comp_arb.sv
// img_rsz_blk_comp_arb: picks one block whose accumulator is complete and offers its
// (x,y) index to Compute on a registered valid/ready channel; on acceptance pulses a
// one-hot flush back to the block buffer and counts blocks per frame.
//   i_clk, i_rst_n (async, active low), i_flush (synchronous frame restart)
//   i_blk_is_enough  : per-block completion flags, one packed row per y
//   o_comp_blk_x/y_msk, o_comp_blk_en : one-hot flush of the accepted block
//   o_comp_blk_x/y_idx, o_comp_blk_vld, i_comp_blk_rdy : Compute channel
//   o_blk_cnt, o_frame_done : accepted-block count and end-of-frame pulse
module img_rsz_blk_comp_arb
  import img_rsz_blk_comp_arb_pkg::*;
#(
  parameter int unsigned BLK_X_NUM = BLK_X_NUM_DEF,
  parameter int unsigned BLK_Y_NUM = BLK_Y_NUM_DEF,
  parameter arb_mode_e   ARB_MODE  = ARB_FIXED
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_flush,
  input  logic [BLK_Y_NUM-1:0][BLK_X_NUM-1:0]        i_blk_is_enough,
  output logic [BLK_X_NUM-1:0]                       o_comp_blk_x_msk,
  output logic [BLK_Y_NUM-1:0]                       o_comp_blk_y_msk,
  output logic                                       o_comp_blk_en,
  output logic [idx_w(BLK_X_NUM)-1:0]                o_comp_blk_x_idx,
  output logic [idx_w(BLK_Y_NUM)-1:0]                o_comp_blk_y_idx,
  output logic                                       o_comp_blk_vld,
  input  logic                                       i_comp_blk_rdy,
  output logic [$clog2(BLK_X_NUM*BLK_Y_NUM+1)-1:0]   o_blk_cnt,
  output logic                                       o_frame_done
);

  localparam int unsigned TOTAL   = BLK_X_NUM * BLK_Y_NUM;
  localparam int unsigned X_IDX_W = idx_w(BLK_X_NUM);
  localparam int unsigned Y_IDX_W = idx_w(BLK_Y_NUM);
  localparam int unsigned L_W     = idx_w(TOTAL);
  localparam int unsigned CNT_W   = $clog2(TOTAL + 1);

  arb_state_e         r_state;
  logic [L_W-1:0]     r_l;
  logic [X_IDX_W-1:0] r_x;
  logic [Y_IDX_W-1:0] r_y;
  logic [L_W-1:0]     r_lptr;
  logic [CNT_W-1:0]   r_cnt;

  arb_state_e         w_state_nxt;
  logic               w_load;
  logic               w_vld;
  logic               w_hs;
  logic               w_last;
  logic [TOTAL-1:0]   w_flat;
  logic [TOTAL-1:0]   w_held_oh;
  logic [TOTAL-1:0]   w_elig;
  logic [L_W-1:0]     w_ptr;
  logic [L_W-1:0]     w_start;
  logic [L_W-1:0]     w_pick_start;
  logic               w_found;
  logic [L_W-1:0]     w_pick_l;
  logic [X_IDX_W-1:0] w_pick_x;
  logic [Y_IDX_W-1:0] w_pick_y;

  // Row-major packing makes bit L of the flat vector block (L % X, L / X).
  assign w_flat    = i_blk_is_enough;
  assign w_vld     = (r_state == ST_HOLD);
  assign w_hs      = w_vld & i_comp_blk_rdy;
  assign w_last    = (r_cnt == CNT_W'(TOTAL - 1));
  // The held block stays excluded even though its flag clears only at the accept edge.
  assign w_held_oh = w_vld ? (TOTAL'(1) << r_l) : '0;
  assign w_elig    = w_flat & ~w_held_oh;

  // On a handshake the pointer advances past the block being accepted this cycle.
  assign w_ptr        = w_hs ? r_l : r_lptr;
  assign w_start      = (w_ptr == L_W'(TOTAL - 1)) ? '0 : w_ptr + 1'b1;
  assign w_pick_start = (ARB_MODE == ARB_RR) ? w_start : '0;

  img_rsz_rr_pick #(
    .TOTAL (TOTAL),
    .L_W   (L_W)
  ) u_pick (
    .i_elig  (w_elig),
    .i_start (w_pick_start),
    .o_found (w_found),
    .o_l     (w_pick_l)
  );

  assign w_pick_x = X_IDX_W'(32'(w_pick_l) % BLK_X_NUM);
  assign w_pick_y = Y_IDX_W'(32'(w_pick_l) / BLK_X_NUM);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_hs) begin
          if (w_found) w_load      = 1'b1;
          else         w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_l     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_lptr  <= L_W'(TOTAL - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_l <= w_pick_l;
        r_x <= w_pick_x;
        r_y <= w_pick_y;
      end
      if (i_flush)   r_lptr <= L_W'(TOTAL - 1);
      else if (w_hs) r_lptr <= r_l;
      if (i_flush)   r_cnt <= '0;
      else if (w_hs) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_comp_blk_vld   = w_vld;
  assign o_comp_blk_x_idx = r_x;
  assign o_comp_blk_y_idx = r_y;
  assign o_comp_blk_en    = w_hs;
  assign o_comp_blk_x_msk = w_hs ? (BLK_X_NUM'(1) << r_x) : '0;
  assign o_comp_blk_y_msk = w_hs ? (BLK_Y_NUM'(1) << r_y) : '0;
  assign o_blk_cnt        = r_cnt;
  assign o_frame_done     = w_hs & w_last & ~i_flush;

endmodule

// File: tb/tb_img_rsz_blk_comp_arb.sv
// Bench for img_rsz_blk_comp_arb: three instances (4x2 fixed, 4x2 round-robin,
// 2x2 round-robin). Expected grants are queued as stimulus is driven and checked
// on every handshake; counters, FrameDone, flush and async reset checked directly.
module tb_img_rsz_blk_comp_arb;
  import img_rsz_blk_comp_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned q_m0[$];
  int unsigned q_m1[$];
  int unsigned q_s[$];
  int unsigned e0, e1, e2;

  // 4x2 fixed priority
  logic [1:0][3:0] m0_in;
  logic            m0_flush, m0_rdy, m0_en, m0_vld, m0_fd;
  logic [3:0]      m0_xm;
  logic [1:0]      m0_ym, m0_xi;
  logic [0:0]      m0_yi;
  logic [3:0]      m0_cnt;
  // 4x2 round-robin
  logic [1:0][3:0] m1_in;
  logic            m1_flush, m1_rdy, m1_en, m1_vld, m1_fd;
  logic [3:0]      m1_xm;
  logic [1:0]      m1_ym, m1_xi;
  logic [0:0]      m1_yi;
  logic [3:0]      m1_cnt;
  // 2x2 round-robin
  logic [1:0][1:0] s_in;
  logic            s_flush, s_rdy, s_en, s_vld, s_fd;
  logic [1:0]      s_xm, s_ym;
  logic [0:0]      s_xi, s_yi;
  logic [2:0]      s_cnt;

  img_rsz_blk_comp_arb #(.BLK_X_NUM(4), .BLK_Y_NUM(2), .ARB_MODE(ARB_FIXED)) u_m0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(m0_flush), .i_blk_is_enough(m0_in),
    .o_comp_blk_x_msk(m0_xm), .o_comp_blk_y_msk(m0_ym), .o_comp_blk_en(m0_en),
    .o_comp_blk_x_idx(m0_xi), .o_comp_blk_y_idx(m0_yi), .o_comp_blk_vld(m0_vld),
    .i_comp_blk_rdy(m0_rdy), .o_blk_cnt(m0_cnt), .o_frame_done(m0_fd)
  );

  img_rsz_blk_comp_arb #(.BLK_X_NUM(4), .BLK_Y_NUM(2), .ARB_MODE(ARB_RR)) u_m1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(m1_flush), .i_blk_is_enough(m1_in),
    .o_comp_blk_x_msk(m1_xm), .o_comp_blk_y_msk(m1_ym), .o_comp_blk_en(m1_en),
    .o_comp_blk_x_idx(m1_xi), .o_comp_blk_y_idx(m1_yi), .o_comp_blk_vld(m1_vld),
    .i_comp_blk_rdy(m1_rdy), .o_blk_cnt(m1_cnt), .o_frame_done(m1_fd)
  );

  img_rsz_blk_comp_arb #(.BLK_X_NUM(2), .BLK_Y_NUM(2), .ARB_MODE(ARB_RR)) u_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(s_flush), .i_blk_is_enough(s_in),
    .o_comp_blk_x_msk(s_xm), .o_comp_blk_y_msk(s_ym), .o_comp_blk_en(s_en),
    .o_comp_blk_x_idx(s_xi), .o_comp_blk_y_idx(s_yi), .o_comp_blk_vld(s_vld),
    .i_comp_blk_rdy(s_rdy), .o_blk_cnt(s_cnt), .o_frame_done(s_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic grant_chk(input string tag, input int unsigned xn, input int unsigned l,
                           input logic [31:0] xi, input logic [31:0] yi,
                           input logic [31:0] xm, input logic [31:0] ym,
                           input logic [31:0] en);
    chk({tag, " x_idx"}, xi, l % xn);
    chk({tag, " y_idx"}, yi, l / xn);
    chk({tag, " x_msk"}, xm, 32'(1) << (l % xn));
    chk({tag, " y_msk"}, ym, 32'(1) << (l / xn));
    chk({tag, " en"},    en, 1);
  endtask

  // Scoreboard: every handshake must match the next queued expected block.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_vld && m0_rdy) begin
        chk("m0 grant expected", 32'(q_m0.size() != 0), 1);
        if (q_m0.size() != 0) begin
          e0 = q_m0.pop_front();
          grant_chk("m0", 4, e0, 32'(m0_xi), 32'(m0_yi), 32'(m0_xm), 32'(m0_ym), 32'(m0_en));
        end
      end
      if (m1_vld && m1_rdy) begin
        chk("m1 grant expected", 32'(q_m1.size() != 0), 1);
        if (q_m1.size() != 0) begin
          e1 = q_m1.pop_front();
          grant_chk("m1", 4, e1, 32'(m1_xi), 32'(m1_yi), 32'(m1_xm), 32'(m1_ym), 32'(m1_en));
        end
      end
      if (s_vld && s_rdy) begin
        chk("s grant expected", 32'(q_s.size() != 0), 1);
        if (q_s.size() != 0) begin
          e2 = q_s.pop_front();
          grant_chk("s", 2, e2, 32'(s_xi), 32'(s_yi), 32'(s_xm), 32'(s_ym), 32'(s_en));
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_in = '0; m0_flush = 1'b0; m0_rdy = 1'b0;
    m1_in = '0; m1_flush = 1'b0; m1_rdy = 1'b0;
    s_in  = '0; s_flush  = 1'b0; s_rdy  = 1'b0;

    // Reset state
    smp();
    chk("rst vld", 32'(m0_vld), 0);
    chk("rst x_idx", 32'(m0_xi), 0);
    chk("rst y_idx", 32'(m0_yi), 0);
    chk("rst en", 32'(m0_en), 0);
    chk("rst x_msk", 32'(m0_xm), 0);
    chk("rst y_msk", 32'(m0_ym), 0);
    chk("rst cnt", 32'(m0_cnt), 0);
    chk("rst frame_done", 32'(m0_fd), 0);
    chk("rst m1 vld", 32'(m1_vld), 0);
    chk("rst s vld", 32'(s_vld), 0);
    nxt();
    rst_n = 1'b1;

    // Fixed priority: (3,0) then (1,1)
    nxt(); m0_in[0][3] = 1'b1; m0_in[1][1] = 1'b1;
    smp(); chk("t1 latency vld", 32'(m0_vld), 0);
    nxt(); q_m0.push_back(3); m0_rdy = 1'b1;
    smp(); chk("t1 first vld", 32'(m0_vld), 1);
    nxt(); m0_in[0][3] = 1'b0; q_m0.push_back(5);
    smp(); chk("t1 second vld", 32'(m0_vld), 1);
    nxt(); m0_in[1][1] = 1'b0; m0_rdy = 1'b0;
    smp(); chk("t1 drain vld", 32'(m0_vld), 0);

    // Hold (2,1) while Rdy low and (0,0) rises
    nxt(); m0_in[1][2] = 1'b1;
    nxt();
    smp(); chk("hold vld", 32'(m0_vld), 1);
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (i == 0) m0_in[0][0] = 1'b1;
      smp();
      chk("hold x_idx", 32'(m0_xi), 2);
      chk("hold y_idx", 32'(m0_yi), 1);
      chk("hold en", 32'(m0_en), 0);
      chk("hold vld stays", 32'(m0_vld), 1);
    end
    nxt(); q_m0.push_back(6); m0_rdy = 1'b1;
    nxt(); m0_in[1][2] = 1'b0; q_m0.push_back(0);
    nxt(); m0_in[0][0] = 1'b0; m0_rdy = 1'b0;
    smp();
    chk("hold drain vld", 32'(m0_vld), 0);
    chk("hold cnt", 32'(m0_cnt), 4);

    // Round-robin with all flags high: 0..7 then wrap to 0
    nxt(); m1_in = '1; m1_rdy = 1'b1;
    for (int i = 0; i < 8; i++) q_m1.push_back(i);
    q_m1.push_back(0);
    smp(); chk("rr latency vld", 32'(m1_vld), 0);
    repeat (9) nxt();
    nxt(); m1_rdy = 1'b0; m1_flush = 1'b1; m1_in = '0;
    smp();
    chk("rr next held x", 32'(m1_xi), 1);
    chk("rr next held y", 32'(m1_yi), 0);
    chk("rr held en", 32'(m1_en), 0);
    nxt(); m1_flush = 1'b0;
    smp();
    chk("flush idle vld", 32'(m1_vld), 0);
    chk("flush idle cnt", 32'(m1_cnt), 0);

    // Flush coincident with the handshake at BlkCnt=2
    nxt(); m1_in[0][2] = 1'b1; m1_in[1][1] = 1'b1; m1_in[1][2] = 1'b1; m1_rdy = 1'b1;
    q_m1.push_back(2); q_m1.push_back(5); q_m1.push_back(6);
    smp(); chk("fl latency vld", 32'(m1_vld), 0);
    nxt();
    smp(); chk("fl cnt0", 32'(m1_cnt), 0);
    nxt(); m1_in[0][2] = 1'b0;
    smp(); chk("fl cnt1", 32'(m1_cnt), 1);
    nxt(); m1_in[1][1] = 1'b0; m1_flush = 1'b1;
    smp();
    chk("fl en", 32'(m1_en), 1);
    chk("fl cnt2", 32'(m1_cnt), 2);
    chk("fl frame_done", 32'(m1_fd), 0);
    nxt(); m1_in[1][2] = 1'b0; m1_flush = 1'b0;
    m1_in[0][0] = 1'b1; m1_in[1][3] = 1'b1; q_m1.push_back(0);
    smp();
    chk("fl post vld", 32'(m1_vld), 0);
    chk("fl post cnt", 32'(m1_cnt), 0);
    nxt(); q_m1.push_back(7);
    nxt(); m1_in[0][0] = 1'b0;
    nxt(); m1_in[1][3] = 1'b0; m1_rdy = 1'b0;
    smp(); chk("fl drain vld", 32'(m1_vld), 0);

    // 2x2 frame: FrameDone on the 4th handshake
    nxt(); s_in = '1; s_rdy = 1'b1;
    for (int i = 0; i < 4; i++) q_s.push_back(i);
    smp(); chk("fd latency vld", 32'(s_vld), 0);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      smp();
      chk("fd cnt", 32'(s_cnt), i - 1);
      chk("fd pulse", 32'(s_fd), 32'(i == 4));
    end
    nxt(); s_in = '0; s_rdy = 1'b0;
    smp();
    chk("fd wrap cnt", 32'(s_cnt), 0);
    chk("fd after", 32'(s_fd), 0);
    chk("fd held vld", 32'(s_vld), 1);
    chk("fd held en", 32'(s_en), 0);

    // Fixed priority, all flags high: held block is excluded, so 0 and 1 alternate
    nxt(); m0_in = '1; m0_rdy = 1'b1;
    q_m0.push_back(0); q_m0.push_back(1); q_m0.push_back(0);
    q_m0.push_back(1); q_m0.push_back(0);
    smp(); chk("alt latency vld", 32'(m0_vld), 0);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      smp();
      chk("alt cnt", 32'(m0_cnt), (4 + i - 1) % 8);
      chk("alt frame_done", 32'(m0_fd), 32'(i == 4));
    end

    // Asynchronous reset between edges while holding (1,0) with Rdy high
    nxt();
    chk("ar pre vld", 32'(m0_vld), 1);
    chk("ar pre cnt", 32'(m0_cnt), 1);
    chk("ar pre en", 32'(m0_en), 1);
    chk("ar pre x_msk", 32'(m0_xm), 2);
    chk("ar pre y_msk", 32'(m0_ym), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar vld", 32'(m0_vld), 0);
    chk("ar cnt", 32'(m0_cnt), 0);
    chk("ar en", 32'(m0_en), 0);
    chk("ar x_msk", 32'(m0_xm), 0);
    chk("ar y_msk", 32'(m0_ym), 0);
    chk("ar x_idx", 32'(m0_xi), 0);
    chk("ar s vld", 32'(s_vld), 0);
    m0_in = '0; m0_rdy = 1'b0;
    nxt();
    nxt(); rst_n = 1'b1;

    chk("m0 sb drained", 32'(q_m0.size()), 0);
    chk("m1 sb drained", 32'(q_m1.size()), 0);
    chk("s sb drained", 32'(q_s.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
